uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver for 8N1 serial frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit).
//  Samples the asynchronous rx_in line on a fractional-accumulator oversample tick.
//  Delivers each received byte with a 1-cycle valid pulse and flags bad stop bits.
//  Pairs with the team's UART transmitter on the host serial link.
// PARAMETERS
//  BAUD               115200    line bit rate, bits/s
//  SOURCE_FREQ        25000000  sourceClk frequency, Hz
//  ACCUMULATOR_WIDTH  16        width of oversample phase accumulator; the carry bit is extra
//  OVERSAMPLE         16        oversample ticks per bit; must be a power of 2, >= 8
// PORTS
//  sourceClk     in   1  single clock; all logic on posedge
//  reset         in   1  synchronous, active-high reset
//  rx_in         in   1  asynchronous serial line; idles high
//  rx_byte       out  8  last good byte; holds its value until the next good frame
//  rx_valid      out  1  1-cycle pulse: rx_byte has just been updated
//  rx_frame_err  out  1  1-cycle pulse: stop bit sampled low; frame discarded
//  rx_busy       out  1  high in every state except RxIdle
// BEHAVIOUR
//  - Reset:
//    - rx_byte=0, rx_valid=0, rx_frame_err=0, rx_busy=0.
//    - State=RxIdle; both synchronizer flops=1; accumulator=0; tick counter=0; bit counter=0.
//  - Reset asserted mid-frame aborts the frame. No valid or error pulse is produced.
//  - rx_in passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
//  - Oversample tick:
//    - INC = ((BAUD*OVERSAMPLE<<(W-4)) + (SOURCE_FREQ>>5)) / (SOURCE_FREQ>>4), computed in 64-bit.
//    - acc <= acc[W-1:0] + INC every cycle. tick = acc[W], the carry bit.
//    - For the default parameters INC = 4832.
//  - States and transitions:
//    - RxIdle: rx_s==0 -> RxStartBit. Clear acc and os_cnt.
//    - RxStartBit: on the tick where os_cnt==OVERSAMPLE/2-1 (mid start bit), sample the line.
//      - Sample 1: false start -> RxIdle. No pulses.
//      - Sample 0: clear os_cnt, bit_cnt=0 -> RxData.
//    - RxData: on the tick where os_cnt==OVERSAMPLE-1 (mid data bit), sample the line.
//      - Shift right; the sample enters at bit 7.
//      - After bit_cnt==7 -> RxStopBit.
//    - RxStopBit: sample at mid stop bit.
//      - Sample 1: rx_byte<=shift, rx_valid=1 for 1 cycle -> RxIdle.
//      - Sample 0: rx_frame_err=1 for 1 cycle, rx_byte unchanged -> RxBreak.
//    - RxBreak: wait for rx_s==1 -> RxIdle. Prevents a held-low line (break) from retriggering.
//  - Pulses are registered and assert the cycle after the sampling tick.
//  - rx_valid and rx_frame_err are never high together.
//  - Back-to-back frames: a new start edge is accepted in RxIdle immediately after the stop sample.
//  - Latency: start edge to rx_valid = 2 sync cycles + ~9.5 bit periods + 1 cycle.
//  - Arithmetic: os_cnt is $clog2(OVERSAMPLE) bits and wraps naturally. bit_cnt is 3 bits.
// CONFIGURATION
//  UART_RX_MAJORITY_EN
//    - Defined: each bit is decided by a 2-of-3 majority of samples taken at mid-1, mid and mid+1 ticks.
//    - Also defined: the decision is still registered on the mid+1 tick.
//    - Undefined: a single sample at the mid tick. No vote registers are synthesized.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    - typedef enum RxState {RxIdle, RxStartBit, RxData, RxStopBit, RxBreak}.
//    - Function baud_inc(baud, freq, width, os) returning INC.
//  - Sub-module uart_baud_gen holds the accumulator and tick:
//    - Inputs: clear, reset. Output: tick.
//    - Reusable by the transmitter with OVERSAMPLE=1.
//  - uart_rx holds the synchronizer, FSM, counters and shift register.
// TESTING (defaults; 1 bit = 217 cycles; drive rx_in from a bench task)
//  1. Frame 0x55, clean -> exactly one rx_valid pulse; rx_byte=0x55; rx_frame_err stays 0.
//  2. 0xA5 then 0x3C with no idle gap -> two rx_valid pulses; bytes 0xA5, 0x3C, in order.
//  3. rx_in low for 50 cycles, then high -> no pulses; rx_busy drops within 1 bit; FSM returns to RxIdle.
//  4. Line low for 12 bit times, then high, then frame 0x81:
//     - One rx_frame_err pulse. No rx_valid for the break.
//     - Then rx_valid with rx_byte=0x81.
//  5. reset pulsed after 4 data bits of 0x33, then frame 0xF0:
//     - All outputs are 0 after reset.
//     - Only one rx_valid, with rx_byte=0xF0.
//  6. UART_RX_MAJORITY_EN defined; frame 0xFF with a 1-cycle low glitch at mid bit 3:
//     - rx_byte=0xFF.
//     - Without the macro, and with the glitch aligned to the sample, rx_byte=0xF7.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the host serial link UART.
// Holds the receiver state enum and the oversample increment function.
package uart_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStartBit,
    RxData,
    RxStopBit,
    RxBreak
  } RxState;

  // Phase increment for the fractional accumulator, rounded to nearest.
  function automatic logic [63:0] baud_inc(
    input logic [63:0] baud,
    input logic [63:0] freq,
    input logic [63:0] width,
    input logic [63:0] os
  );
    logic [63:0] num;
    num = ((baud * os) << (width - 64'd4)) + (freq >> 5);
    return num / (freq >> 4);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional-accumulator tick generator.
// Ports: sourceClk, reset (sync, high), clear (restart phase), tick (carry).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD              = 115200,
  parameter int SOURCE_FREQ       = 25000000,
  parameter int ACCUMULATOR_WIDTH = 16,
  parameter int OVERSAMPLE        = 16
) (
  input  logic sourceClk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = ACCUMULATOR_WIDTH;

  localparam logic [63:0] INC64 = baud_inc(
    64'(BAUD), 64'(SOURCE_FREQ), 64'(W), 64'(OVERSAMPLE));

  localparam logic [W:0] INC = INC64[W:0];

  logic [W:0] acc;

  // Carry is dropped each cycle so tick is a one-cycle pulse.
  always_ff @(posedge sourceClk) begin
    if (reset || clear) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[W-1:0]} + INC;
    end
  end

  assign tick = acc[W];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop sync, oversampled bit decisions.
// Ports: sourceClk, reset (sync, high), rx_in (serial, idles high),
// rx_byte (last good byte), rx_valid / rx_frame_err (1-cycle pulses),
// rx_busy (not idle). Option UART_RX_MAJORITY_EN: 2-of-3 vote per bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD              = 115200,
  parameter int SOURCE_FREQ       = 25000000,
  parameter int ACCUMULATOR_WIDTH = 16,
  parameter int OVERSAMPLE        = 16
) (
  input  logic       sourceClk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int OSW = $clog2(OVERSAMPLE);

  localparam logic [OSW-1:0] OS_ONE    = OSW'(1);
  localparam logic [OSW-1:0] START_MID = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] DATA_MID  = OSW'(OVERSAMPLE - 1);

  logic rx_m;
  logic rx_s;

  always_ff @(posedge sourceClk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  logic tick;
  logic clear;

  uart_baud_gen #(
    .BAUD              (BAUD),
    .SOURCE_FREQ       (SOURCE_FREQ),
    .ACCUMULATOR_WIDTH (ACCUMULATOR_WIDTH),
    .OVERSAMPLE        (OVERSAMPLE)
  ) u_baud (
    .sourceClk (sourceClk),
    .reset     (reset),
    .clear     (clear),
    .tick      (tick)
  );

  logic bit_val;

`ifdef UART_RX_MAJORITY_EN
  // Decide one tick late so mid-1, mid and mid+1 all vote. Reload
  // of 1 after the start decision keeps later decisions at mid+1.
  localparam logic [OSW-1:0] START_AT     = START_MID + OS_ONE;
  localparam logic [OSW-1:0] DATA_AT      = DATA_MID + OS_ONE;
  localparam logic [OSW-1:0] START_RELOAD = OS_ONE;

  logic vote_a;
  logic vote_b;

  always_ff @(posedge sourceClk) begin
    if (reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (tick) begin
      vote_a <= vote_b;
      vote_b <= rx_s;
    end
  end

  assign bit_val = (vote_a & vote_b) |
                   (vote_a & rx_s) |
                   (vote_b & rx_s);
`else
  localparam logic [OSW-1:0] START_AT     = START_MID;
  localparam logic [OSW-1:0] DATA_AT      = DATA_MID;
  localparam logic [OSW-1:0] START_RELOAD = '0;

  assign bit_val = rx_s;
`endif

  RxState         state;
  RxState         state_nxt;
  logic [OSW-1:0] os_cnt;
  logic [OSW-1:0] os_nxt;
  logic [2:0]     bit_cnt;
  logic [2:0]     bit_nxt;
  logic [7:0]     shift;
  logic [7:0]     shift_nxt;
  logic [7:0]     byte_nxt;
  logic           valid_nxt;
  logic           err_nxt;
  logic [OSW-1:0] sample_at;
  logic           sample;

  assign sample_at = (state == RxStartBit) ? START_AT : DATA_AT;
  assign sample    = tick && (os_cnt == sample_at);

  always_ff @(posedge sourceClk) begin
    if (reset) begin
      state        <= RxIdle;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      os_cnt       <= os_nxt;
      bit_cnt      <= bit_nxt;
      shift        <= shift_nxt;
      rx_byte      <= byte_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    os_nxt    = tick ? os_cnt + OS_ONE : os_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    byte_nxt  = rx_byte;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    clear     = 1'b0;
    unique case (state)
      RxIdle: begin
        os_nxt = '0;
        if (!rx_s) begin
          clear     = 1'b1;
          state_nxt = RxStartBit;
        end
      end
      RxStartBit: begin
        if (sample) begin
          if (bit_val) begin
            state_nxt = RxIdle;
          end else begin
            os_nxt    = START_RELOAD;
            bit_nxt   = '0;
            state_nxt = RxData;
          end
        end
      end
      RxData: begin
        if (sample) begin
          shift_nxt = {bit_val, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = RxStopBit;
          end
        end
      end
      RxStopBit: begin
        if (sample) begin
          if (bit_val) begin
            byte_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = RxIdle;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = RxBreak;
          end
        end
      end
      RxBreak: begin
        if (rx_s) begin
          state_nxt = RxIdle;
        end
      end
      default: begin
        state_nxt = RxIdle;
      end
    endcase
  end

  assign rx_busy = (state != RxIdle);

endmodule
